timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
- Parametrised multi-channel down-counting timer for the SoC memory-mapped peripheral space.
- Next generation of the single-period timer. Adds:
  - per-channel period, prescaler and one-shot/periodic mode;
  - readable count;
  - write-1-to-clear status;
  - per-channel and combined interrupt flags.
- Sits on the CPU data bus next to the other addr/dataIn/we peripherals. `flag` feeds the interrupt controller.

Parameters:
- NUM_CH, 2, number of channels, legal range 1..4.
- WIDTH, 32, counter/period width, legal range 8..32.
- DEFAULT_PERIOD, 200, reset PERIOD of channel 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write strobe; a write is sampled on a rising edge when we=1 and addr[4]=1.
- addr  in  5  register address: addr[4]=1 selects the block, addr[3:2]=channel, addr[1:0]=register.
- dataIn  in  32  write data.
- dataOut  out  32  combinational read data for addr.
- irq  out  NUM_CH  per-channel interrupt = STATUS.expired & CTRL.irq_en.
- flag  out  1  OR-reduction of irq.

Behaviour:
- Register map (offset = addr[1:0]):
  - 0 CTRL:
    - [0] en.
    - [1] mode: 0 = periodic auto-reload, 1 = one-shot.
    - [2] irq_en.
    - [15:8] presc.
    - All other bits read 0.
  - 1 PERIOD[WIDTH-1:0].
  - 2 COUNT: read-only; writes ignored.
  - 3 STATUS: [0] expired, write-1-to-clear.
- Address decode:
  - Channel index >= NUM_CH, or addr[4]=0: writes ignored, dataOut=0.
  - Unused upper bits read 0.
- Reset values:
  - Channel 0: CTRL = en=1, mode=0, irq_en=1, presc=0; PERIOD = COUNT = DEFAULT_PERIOD.
  - Other channels: CTRL=0, PERIOD=0, COUNT=0.
  - All STATUS=0, prescaler counters=0, irq=0, flag=0.
  - Rationale: after reset, channel 0 behaves exactly like the previous-generation timer with no software writes.
- Tick generation, per channel, only while en=1:
  - Prescaler counter pc increments each clk.
  - tick=1 when pc==presc; pc then returns to 0.
  - presc=0 gives a tick every cycle.
- Counting on a tick:
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: expiry.
    - STATUS.expired <= 1.
    - mode=0: COUNT <= PERIOD.
    - mode=1: COUNT stays 0 and en <= 0.
  - Expiry interval = (PERIOD+1)*(presc+1) clocks.
  - PERIOD=0 expires on every tick.
- Disable: en=0 freezes COUNT and pc. They are not cleared.
- Write side-effects (take effect on the edge where we=1; visible the next cycle):
  - PERIOD write: loads PERIOD and COUNT with dataIn, and clears pc.
  - CTRL write with en 0->1 in one-shot mode and COUNT==0: reloads COUNT <= PERIOD (re-arm).
  - CTRL write changing presc: clears pc.
- Simultaneous events:
  - Expiry in the same cycle as a STATUS W1C: set wins, expired stays 1.
  - Expiry in the same cycle as a PERIOD write: the write wins for COUNT; STATUS is still set.
  - CTRL write clearing en in the same cycle as a tick: no count/expiry that cycle.
- irq/flag are registered from STATUS/CTRL state: irq asserts the cycle after expiry is recorded, not combinationally from the tick.
- rst asserted mid-count: on the next edge all state returns to reset values regardless of we. Reset has priority over writes.
- Width rule: dataIn is truncated to WIDTH bits. COUNT/PERIOD are zero-extended on read.

Decomposition:
- Package timer_pkg:
  - Register offsets: CTRL=0, PERIOD=1, COUNT=2, STATUS=3.
  - CTRL bit positions and presc field range.
  - Block-select bit index (4).
  - MAX_CH=4.
- Sub-module timer_channel (WIDTH, RST_EN, RST_PERIOD):
  - One channel's CTRL/PERIOD/COUNT/STATUS registers, prescaler and expiry logic.
  - Per-channel write-enable and read-mux inputs.
- timer_multi:
  - Decodes addr.
  - Generates NUM_CH instances.
  - Muxes dataOut.
  - ORs irq into flag.

Test Plan:
- Reset, no writes: flag rises after exactly 201 clocks; COUNT reads 200 again the cycle after expiry. Repeats every 201 clocks while STATUS is never cleared; expired stays 1.
- Write STATUS ch0 (addr 5'b10011) with 1: flag drops next cycle. Issue the write on the exact expiry cycle: flag stays 1 (set wins).
- Ch1: PERIOD=9 (addr 5'b10101), then CTRL=0x0000_0307 (presc=3, one-shot, irq_en, en):
  - irq[1] after 40 clocks;
  - CTRL.en reads 0;
  - COUNT stays 0;
  - no second expiry over 200 further clocks.
- Ch0: mid-count PERIOD write of 500 → COUNT reads 500 next cycle; next expiry 501 clocks later. Pulse rst mid-count → CTRL/PERIOD/COUNT return to reset values, irq=0.
- Ch0: write CTRL en=0 at COUNT=50 → COUNT holds 50 for 100 clocks. Re-enable → expiry after 51 more clocks.
- Invalid access: write/read addr 5'b11000 with NUM_CH=2, and addr 5'b00101 → no state change, dataOut=0. Write COUNT → ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, CTRL field layout and helpers for the multi-channel timer.
package timer_pkg;
    localparam int unsigned MAX_CH   = 4;
    localparam int unsigned SEL_BIT  = 4;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PRESC_W  = 8;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned PRESC_LO    = 8;
    localparam int unsigned PRESC_HI    = 15;
    localparam int unsigned ST_EXPIRED  = 0;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               irq_en;
        logic               mode;
        logic               en;
    } ctrl_t;

    // Bus image of CTRL; undefined bits read as zero.
    function automatic logic [DATA_W-1:0] ctrl_word(input ctrl_t c);
        logic [DATA_W-1:0] w;
        w                    = '0;
        w[CTRL_EN]           = c.en;
        w[CTRL_MODE]         = c.mode;
        w[CTRL_IRQ_EN]       = c.irq_en;
        w[PRESC_HI:PRESC_LO] = c.presc;
        return w;
    endfunction
endpackage

// File: rtl/timer_multi_if.sv
// CPU data-bus slice seen by the timer block.
interface timer_multi_if;
    import timer_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;

    modport master (output we, addr, dataIn, input dataOut);
    modport slave  (input we, addr, dataIn, output dataOut);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PERIOD/COUNT/STATUS, prescaler and expiry logic.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          RST_EN     = 1'b0,
    parameter int unsigned RST_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  reg_e              sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c,
    output logic              irq
);
    ctrl_t              ctrl, ctrl_n;
    logic [WIDTH-1:0]   period, period_n;
    logic [WIDTH-1:0]   count, count_n;
    logic [PRESC_W-1:0] pc, pc_n;
    logic               expired, expired_n;
    logic               irq_n;
    logic               ctrl_wr, run, tick, expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '{presc: '0, irq_en: RST_EN, mode: 1'b0, en: RST_EN};
            period  <= WIDTH'(RST_PERIOD);
            count   <= WIDTH'(RST_PERIOD);
            pc      <= '0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ctrl    <= ctrl_n;
            period  <= period_n;
            count   <= count_n;
            pc      <= pc_n;
            expired <= expired_n;
            irq     <= irq_n;
        end
    end

    // Counting first, then bus writes override where they collide.
    always_comb begin
        ctrl_n    = ctrl;
        period_n  = period;
        count_n   = count;
        pc_n      = pc;
        expired_n = expired;

        ctrl_wr = we && (sel == REG_CTRL);
        run     = ctrl.en && !(ctrl_wr && !wdata[CTRL_EN]);
        tick    = run && (pc == ctrl.presc);
        expire  = tick && (count == '0);

        if (run) pc_n = tick ? '0 : pc + PRESC_W'(1);

        if (tick) begin
            if (!expire)        count_n   = count - WIDTH'(1);
            else if (ctrl.mode) ctrl_n.en = 1'b0;
            else                count_n   = period;
        end
        if (expire) expired_n = 1'b1;

        if (we) begin
            case (sel)
                REG_CTRL: begin
                    ctrl_n.en     = wdata[CTRL_EN];
                    ctrl_n.mode   = wdata[CTRL_MODE];
                    ctrl_n.irq_en = wdata[CTRL_IRQ_EN];
                    ctrl_n.presc  = wdata[PRESC_HI:PRESC_LO];
                    if (ctrl_n.presc != ctrl.presc) pc_n = '0;
                    // Re-arm a spent one-shot channel on enable.
                    if (!ctrl.en && ctrl_n.en && ctrl_n.mode && (count == '0)) count_n = period;
                end
                REG_PERIOD: begin
                    period_n = WIDTH'(wdata);
                    count_n  = WIDTH'(wdata);
                    pc_n     = '0;
                end
                REG_COUNT: ;
                REG_STATUS: begin
                    if (wdata[ST_EXPIRED] && !expire) expired_n = 1'b0;
                end
            endcase
        end

        irq_n = expired_n && ctrl_n.irq_en;
    end

    always_comb begin
        rdata_c = '0;
        case (sel)
            REG_CTRL:   rdata_c = ctrl_word(ctrl);
            REG_PERIOD: rdata_c = DATA_W'(period);
            REG_COUNT:  rdata_c = DATA_W'(count);
            REG_STATUS: rdata_c[ST_EXPIRED] = expired;
        endcase
    end
endmodule

// File: rtl/timer_multi.sv
// Multi-channel down-counting timer: address decode, channel array, read mux, irq merge.
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 200
) (
    input  logic              clk,
    input  logic              rst,
    timer_multi_if.slave      bus,
    output logic [NUM_CH-1:0] irq,
    output logic              flag
);
    logic [1:0]        ch;
    reg_e              sel;
    logic              hit;
    logic [DATA_W-1:0] rdata [NUM_CH];

    assign ch  = bus.addr[3:2];
    assign sel = reg_e'(bus.addr[1:0]);
    assign hit = bus.addr[SEL_BIT] && (32'(ch) < NUM_CH);

    // Channel 0 comes out of reset running, matching the single-period timer.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .WIDTH      (WIDTH),
            .RST_EN     (i == 0),
            .RST_PERIOD ((i == 0) ? DEFAULT_PERIOD : 0)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .we      (bus.we && hit && (ch == 2'(i))),
            .sel     (sel),
            .wdata   (bus.dataIn),
            .rdata_c (rdata[i]),
            .irq     (irq[i])
        );
    end

    always_comb begin
        bus.dataOut = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (hit && (ch == 2'(i))) bus.dataOut = rdata[i];
        end
    end

    assign flag = |irq;
endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi (NUM_CH=2, WIDTH=32, DEFAULT_PERIOD=200).
module tb_timer_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] irq;
    logic       flag;
    int unsigned tests = 0;
    int unsigned fails = 0;

    timer_multi_if bus ();

    timer_multi #(.NUM_CH(2), .WIDTH(32), .DEFAULT_PERIOD(200)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .irq  (irq),
        .flag (flag)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr = a;
        #1;
        d = bus.dataOut;
        chk(tag, d, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we     = 1'b1;
        bus.addr   = a;
        bus.dataIn = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    // Comments E<n> name the clock edge (counted from reset release) just passed.
    initial begin
        bus.we = 1'b0; bus.addr = '0; bus.dataIn = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        rchk("rst_ctrl0", 5'h10, 32'h5);
        rchk("rst_period0", 5'h11, 32'd200);
        rchk("rst_count0", 5'h12, 32'd200);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);

        step(1);    // E1
        rchk("count_e1", 5'h12, 32'd199);
        rchk("status_e1", 5'h13, 32'h0);
        rchk("rst_ctrl1", 5'h14, 32'h0);

        step(199);  // E200
        chk("flag_e200", 32'(flag), 32'h0);
        rchk("count_e200", 5'h12, 32'd0);
        step(1);    // E201: first expiry
        chk("flag_e201", 32'(flag), 32'h1);
        chk("irq_e201", 32'(irq), 32'h1);
        rchk("reload_e201", 5'h12, 32'd200);
        rchk("status_e201", 5'h13, 32'h1);

        step(200);  // E401
        chk("flag_e401", 32'(flag), 32'h1);
        rchk("count_e401", 5'h12, 32'd0);
        step(1);    // E402: second expiry
        rchk("reload_e402", 5'h12, 32'd200);
        rchk("status_e402", 5'h13, 32'h1);

        wr(5'h13, 32'h1);   // E403
        chk("w1c_flag", 32'(flag), 32'h0);
        rchk("w1c_status", 5'h13, 32'h0);
        rchk("count_e403", 5'h12, 32'd199);

        step(199);  // E602
        rchk("count_e602", 5'h12, 32'd0);
        chk("flag_e602", 32'(flag), 32'h0);
        wr(5'h13, 32'h1);   // E603: expiry and W1C together
        chk("setwins_flag", 32'(flag), 32'h1);
        rchk("setwins_status", 5'h13, 32'h1);
        rchk("setwins_count", 5'h12, 32'd200);
        wr(5'h13, 32'h1);   // E604
        chk("w1c2_flag", 32'(flag), 32'h0);

        wr(5'h15, 32'd9);        // E605
        wr(5'h14, 32'h0000_0307); // E606
        rchk("ch1_period", 5'h15, 32'd9);
        rchk("ch1_count", 5'h16, 32'd9);
        step(39);   // E645
        chk("ch1_irq_e645", 32'(irq), 32'h0);
        rchk("ch1_count_e645", 5'h16, 32'd0);
        step(1);    // E646: one-shot expiry
        chk("ch1_irq_e646", 32'(irq), 32'h2);
        rchk("ch1_ctrl_off", 5'h14, 32'h306);
        rchk("ch1_count_e646", 5'h16, 32'd0);
        wr(5'h17, 32'h1);   // E647
        chk("ch1_w1c_irq", 32'(irq), 32'h0);
        step(200);  // E847
        chk("oneshot_quiet_irq", 32'(irq), 32'h1);
        rchk("ch1_count_e847", 5'h16, 32'd0);
        rchk("ch0_count_e847", 5'h12, 32'd157);

        wr(5'h11, 32'd500);  // E848
        rchk("period_wr_count", 5'h12, 32'd500);
        rchk("period_wr_period", 5'h11, 32'd500);
        wr(5'h13, 32'h1);   // E849
        chk("flag_e849", 32'(flag), 32'h0);
        rchk("count_e849", 5'h12, 32'd499);
        step(499);  // E1348
        chk("irq_e1348", 32'(irq), 32'h0);
        rchk("count_e1348", 5'h12, 32'd0);
        step(1);    // E1349
        chk("irq_e1349", 32'(irq), 32'h1);
        rchk("reload_e1349", 5'h12, 32'd500);

        step(10);   // E1359
        rchk("count_e1359", 5'h12, 32'd490);
        rst = 1'b1; bus.we = 1'b1; bus.addr = 5'h11; bus.dataIn = 32'd7;
        step(1);    // E1360: reset beats the write
        rst = 1'b0; bus.we = 1'b0;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_flag", 32'(flag), 32'h0);
        rchk("mid_rst_count", 5'h12, 32'd200);
        rchk("mid_rst_period", 5'h11, 32'd200);
        rchk("mid_rst_ctrl", 5'h10, 32'h5);
        step(1);    // E1361
        rchk("count_e1361", 5'h12, 32'd199);
        rchk("mid_rst_ch1_period", 5'h15, 32'd0);
        rchk("mid_rst_ch1_ctrl", 5'h14, 32'h0);

        step(149);  // E1510
        rchk("count_e1510", 5'h12, 32'd50);
        wr(5'h10, 32'h4);   // E1511: tick suppressed by disable
        rchk("pause_count", 5'h12, 32'd50);
        rchk("pause_ctrl", 5'h10, 32'h4);
        step(100);  // E1611
        rchk("paused_count", 5'h12, 32'd50);
        chk("paused_flag", 32'(flag), 32'h0);
        wr(5'h10, 32'h5);   // E1612
        rchk("resume_count", 5'h12, 32'd50);
        step(50);   // E1662
        rchk("count_e1662", 5'h12, 32'd0);
        chk("irq_e1662", 32'(irq), 32'h0);
        step(1);    // E1663
        chk("irq_e1663", 32'(irq), 32'h1);
        rchk("reload_e1663", 5'h12, 32'd200);

        rchk("bad_ch_read", 5'h18, 32'h0);
        wr(5'h18, 32'hFFFF_FFFF);   // E1664
        wr(5'h05, 32'h0000_1234);   // E1665
        rchk("unsel_read", 5'h05, 32'h0);
        rchk("unsel_ch1_period", 5'h15, 32'h0);
        rchk("bad_ch_ctrl0", 5'h10, 32'h5);
        wr(5'h12, 32'h77);          // E1666
        rchk("count_ro", 5'h12, 32'd197);
        rchk("period_kept", 5'h11, 32'd200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
